// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory copy arbiter.
// The state encoding is used by the FSM in dmem_copy_arbiter.
package dmem_arb_pkg;

  localparam int DEFAULT_AW         = 8;
  localparam int DEFAULT_DW         = 8;
  localparam int DEFAULT_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_arb_mux.sv
// Steers either the core load/store path or the copy engine onto the data memory port.
// The core is refused (stalled) only when the engine owns the port and the core wants it.
module dmem_arb_mux #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          engine_sel,
  input  logic          core_req,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic          core_read_en,
  input  logic          core_write_en,
  input  logic [AW-1:0] eng_addr,
  input  logic [DW-1:0] eng_wdata,
  input  logic          eng_read_en,
  input  logic          eng_write_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read_en,
  output logic          mem_write_en,
  output logic          core_stall
);

  always_comb begin
    mem_addr     = core_addr;
    mem_wdata    = core_wdata;
    mem_read_en  = core_read_en;
    mem_write_en = core_write_en;
    if (engine_sel) begin
      mem_addr     = eng_addr;
      mem_wdata    = eng_wdata;
      mem_read_en  = eng_read_en;
      mem_write_en = eng_write_en;
    end
    core_stall = engine_sel & core_req;
  end

endmodule

// File: rtl/dmem_copy_arbiter.sv
// Shares single-port data memory between the core and a byte-serial block-copy engine.
// The core normally wins; a starvation counter forces one engine cycle every STARVE_MAX losses.
module dmem_copy_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = DEFAULT_AW,
  parameter int DW         = DEFAULT_DW,
  parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic          core_read_en,
  input  logic          core_write_en,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          dma_start,
  input  logic [AW-1:0] dma_src,
  input  logic [AW-1:0] dma_dst,
  input  logic [AW-1:0] dma_len,
  output logic          dma_busy,
  output logic          dma_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read_en,
  output logic          mem_write_en,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [DW-1:0] rd_buf_q, rd_buf_d;

  logic          core_req;
  logic          engine_win;
  logic          engine_sel;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_wdata;
  logic          eng_read_en;
  logic          eng_write_en;
  logic          mux_write_en;

  assign core_req   = core_read_en | core_write_en;
  assign engine_win = !core_req | (starve_cnt_q == SW'(STARVE_MAX));
  assign core_rdata = mem_rdata;
  assign dma_busy   = (state_q != IDLE);
  assign dma_done   = (state_q == DONE);

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    idx_d        = idx_q;
    starve_cnt_d = starve_cnt_q;
    rd_buf_d     = rd_buf_q;
    engine_sel   = 1'b0;
    eng_addr     = '0;
    eng_wdata    = '0;
    eng_read_en  = 1'b0;
    eng_write_en = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dma_start) begin
          src_d   = dma_src;
          dst_d   = dma_dst;
          len_d   = dma_len;
          idx_d   = '0;
          state_d = (dma_len != '0) ? RD : DONE;
        end
      end
      RD, WR: begin
        if (engine_win) begin
          engine_sel   = 1'b1;
          starve_cnt_d = '0;
          if (state_q == RD) begin
            eng_addr    = src_q + idx_q;
            eng_read_en = 1'b1;
            rd_buf_d    = mem_rdata;
            state_d     = WR;
          end else begin
            eng_addr     = dst_q + idx_q;
            eng_wdata    = rd_buf_q;
            eng_write_en = 1'b1;
            if (idx_q == len_q - AW'(1)) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + AW'(1);
              state_d = RD;
            end
          end
        end else begin
          starve_cnt_d = starve_cnt_q + SW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      starve_cnt_q <= '0;
      rd_buf_q     <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      starve_cnt_q <= starve_cnt_d;
      rd_buf_q     <= rd_buf_d;
    end
  end

  dmem_arb_mux #(
    .AW(AW),
    .DW(DW)
  ) u_mux (
    .engine_sel   (engine_sel),
    .core_req     (core_req),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_read_en (core_read_en),
    .core_write_en(core_write_en),
    .eng_addr     (eng_addr),
    .eng_wdata    (eng_wdata),
    .eng_read_en  (eng_read_en),
    .eng_write_en (eng_write_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mux_write_en),
    .core_stall   (core_stall)
  );

  // A reset cycle must never corrupt memory, whoever currently owns the port.
  assign mem_write_en = mux_write_en & ~reset;

endmodule
